// File: rtl/seq_gen_1011_if.sv
// Serial link bundle between the 1011 stimulus generator and its consumer.
// master = generator side, slave = detector/bench side.
interface seq_gen_1011_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 3
);
  logic             load;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             PO;
  logic             valid;
  logic             busy;
  logic             done;
  logic             exp_hit;
  logic [CNT_W-1:0] exp_cnt;

  modport master (
    input  load, din, ready,
    output PO, valid, busy, done, exp_hit, exp_cnt
  );

  modport slave (
    output load, din, ready,
    input  PO, valid, busy, done, exp_hit, exp_cnt
  );
endinterface

// File: rtl/seq_gen_1011.sv
// Serial 1011 stimulus transmitter: shifts a parallel frame out MSB-first with
// valid/ready and runs a golden non-overlapping Mealy 1011 detector alongside it.
module seq_gen_1011 #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 3
) (
  input  logic                clk,
  input  logic                reset,
  seq_gen_1011_if.master      bus
);

  localparam int BCW = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} track_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shreg;
  logic [BCW-1:0]   r_bitCnt;
  track_t           r_track;
  track_t           w_trackNext;
  logic [CNT_W-1:0] r_expCnt;

  logic w_valid;
  logic w_po;
  logic w_busy;
  logic w_done;
  logic w_hit;
  logic w_xfer;
  logic w_lastBit;

  assign w_xfer    = w_valid & bus.ready;
  assign w_lastBit = (r_bitCnt == BCW'(WIDTH - 1));
  assign w_hit     = w_valid & w_po & (r_track == S3);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.load) w_nextState = SHIFT;
      SHIFT:   if (w_xfer && w_lastBit) w_nextState = DONE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_valid = 1'b0;
    w_po    = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      SHIFT: begin
        w_valid = 1'b1;
        w_po    = r_shreg[WIDTH-1];
        w_busy  = 1'b1;
      end
      DONE: begin
        w_done = 1'b1;
        w_busy = 1'b1;
      end
      default: ;
    endcase
  end

  // Match on S3 with a 1 restarts from S0 so matches never share bits.
  always_comb begin
    w_trackNext = r_track;
    case (r_track)
      S0: w_trackNext = w_po ? S1 : S0;
      S1: w_trackNext = w_po ? S1 : S2;
      S2: w_trackNext = w_po ? S3 : S0;
      S3: w_trackNext = w_po ? S0 : S2;
      default: w_trackNext = S0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shreg  <= '0;
      r_bitCnt <= '0;
      r_track  <= S0;
      r_expCnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.load) begin
            r_shreg  <= bus.din;
            r_bitCnt <= '0;
            r_track  <= S0;
            r_expCnt <= '0;
          end
        end
        SHIFT: begin
          if (w_xfer) begin
            r_shreg  <= {r_shreg[WIDTH-2:0], 1'b0};
            r_bitCnt <= r_bitCnt + 1'b1;
            r_track  <= w_trackNext;
            if (w_hit && (r_expCnt != CNT_MAX)) r_expCnt <= r_expCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.PO      = w_po;
  assign bus.valid   = w_valid;
  assign bus.busy    = w_busy;
  assign bus.done    = w_done;
  assign bus.exp_hit = w_hit;
  assign bus.exp_cnt = r_expCnt;

endmodule

// File: tb/tb_seq_gen_1011.sv
// Self-checking bench for seq_gen_1011; expected hits come from a greedy
// leftmost non-overlapping search for "1011" over the frame bits.
module tb_seq_gen_1011;

  localparam int WIDTH = 16;
  localparam int CNT_W = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  bit   expHit [WIDTH];
  int   expTotal;

  seq_gen_1011_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  seq_gen_1011 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: scan send-order bits, a match consumes its four bits.
  function automatic void build_model(input logic [WIDTH-1:0] frame);
    int pos;
    int hits;
    pos = 0;
    hits = 0;
    for (int i = 0; i < WIDTH; i++) expHit[i] = 1'b0;
    while (pos + 3 < WIDTH) begin
      if (frame[WIDTH-1-pos] == 1'b1 && frame[WIDTH-2-pos] == 1'b0 &&
          frame[WIDTH-3-pos] == 1'b1 && frame[WIDTH-4-pos] == 1'b1) begin
        expHit[pos+3] = 1'b1;
        hits++;
        pos += 4;
      end else begin
        pos++;
      end
    end
    expTotal = (hits > CNT_MAX) ? CNT_MAX : hits;
  endfunction

  // mode: 0 = ready always high, 1 = ready 1,0,1,0..., 2 = random ready.
  task automatic run_frame(input string name, input logic [WIDTH-1:0] frame,
                           input int mode, input bit injectLoad, input int expDoneCycle);
    int bitIdx;
    int runCnt;
    int doneAt;
    bit rdy;
    build_model(frame);
    @(negedge clk);
    bus.load  = 1'b1;
    bus.din   = frame;
    bus.ready = 1'b0;
    bitIdx = 0;
    runCnt = 0;
    doneAt = -1;
    for (int k = 1; k <= 300 && doneAt < 0; k++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (bitIdx < WIDTH) begin
        checks++;
        if (bus.valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
          failures++;
          $display("[TB] FAIL %s shift_ctrl bit %0d: valid/busy/done got %b%b%b expected 110",
                   name, bitIdx, bus.valid, bus.busy, bus.done);
        end
        checks++;
        if (bus.PO !== frame[WIDTH-1-bitIdx]) begin
          failures++;
          $display("[TB] FAIL %s po bit %0d: got %b expected %b",
                   name, bitIdx, bus.PO, frame[WIDTH-1-bitIdx]);
        end
        checks++;
        if (bus.exp_hit !== expHit[bitIdx]) begin
          failures++;
          $display("[TB] FAIL %s exp_hit bit %0d: got %b expected %b",
                   name, bitIdx, bus.exp_hit, expHit[bitIdx]);
        end
        checks++;
        if (bus.exp_cnt !== CNT_W'(runCnt)) begin
          failures++;
          $display("[TB] FAIL %s exp_cnt bit %0d: got %0d expected %0d",
                   name, bitIdx, bus.exp_cnt, runCnt);
        end
      end else begin
        doneAt = k;
        checks++;
        if (bus.done !== 1'b1 || bus.valid !== 1'b0 || bus.PO !== 1'b0 || bus.busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL %s done_ctrl: done/valid/PO/busy got %b%b%b%b expected 1001",
                   name, bus.done, bus.valid, bus.PO, bus.busy);
        end
        checks++;
        if (bus.exp_cnt !== CNT_W'(expTotal)) begin
          failures++;
          $display("[TB] FAIL %s final_cnt: got %0d expected %0d", name, bus.exp_cnt, expTotal);
        end
      end
      if (doneAt < 0) begin
        if (mode == 0)      rdy = 1'b1;
        else if (mode == 1) rdy = k[0];
        else                rdy = 1'($urandom_range(0, 1));
        bus.ready = rdy;
        if (injectLoad && k == 5) begin
          bus.load = 1'b1;
          bus.din  = ~frame;
        end
        if (rdy && bitIdx < WIDTH) begin
          if (expHit[bitIdx] && runCnt < CNT_MAX) runCnt++;
          bitIdx++;
        end
      end
    end
    checks++;
    if (doneAt < 0) begin
      failures++;
      $display("[TB] FAIL %s timeout: got no done within 300 cycles, expected done", name);
      return;
    end
    if (expDoneCycle > 0) begin
      checks++;
      if (doneAt != expDoneCycle) begin
        failures++;
        $display("[TB] FAIL %s done_latency: got %0d expected %0d", name, doneAt, expDoneCycle);
      end
    end
    bus.load  = injectLoad;
    bus.din   = ~frame;
    bus.ready = 1'b1;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      bus.load = 1'b0;
      checks++;
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
          bus.PO !== 1'b0 || bus.exp_cnt !== CNT_W'(expTotal)) begin
        failures++;
        $display("[TB] FAIL %s idle_after_done: valid/busy/done/PO got %b%b%b%b cnt %0d expected 0000 cnt %0d",
                 name, bus.valid, bus.busy, bus.done, bus.PO, bus.exp_cnt, expTotal);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.load  = 1'b0;
    bus.din   = '0;
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.PO !== 1'b0 || bus.valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.done !== 1'b0 || bus.exp_hit !== 1'b0 || bus.exp_cnt !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: PO/valid/busy/done/hit got %b%b%b%b%b cnt %0d expected 00000 cnt 0",
               bus.PO, bus.valid, bus.busy, bus.done, bus.exp_hit, bus.exp_cnt);
    end
    bus.load = 1'b1;
    bus.din  = 16'hBBBB;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_over_load: busy/valid got %b%b expected 00", bus.busy, bus.valid);
    end
    bus.load = 1'b0;
    reset    = 1'b0;
  endtask

  task automatic test_continuous();
    run_frame("bbbb", 16'hBBBB, 0, 1'b0, 17);
    run_frame("b6c0", 16'hB6C0, 0, 1'b0, 17);
  endtask

  task automatic test_back_to_back();
    run_frame("zeros", 16'h0000, 0, 1'b1, 17);
    run_frame("ones", 16'hFFFF, 0, 1'b0, 17);
  endtask

  task automatic test_ready_toggle();
    run_frame("toggle", 16'hBBBB, 1, 1'b0, 32);
  endtask

  task automatic test_ignored_load();
    run_frame("ign_load", 16'hBBBB, 0, 1'b1, 17);
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    bus.load  = 1'b1;
    bus.din   = 16'hBBBB;
    bus.ready = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      bus.load = 1'b0;
    end
    checks++;
    if (bus.exp_cnt !== CNT_W'(1) || bus.PO !== 1'b1 || bus.valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midframe_state: cnt/PO/valid got %0d/%b/%b expected 1/1/1",
               bus.exp_cnt, bus.PO, bus.valid);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.exp_cnt !== '0 || bus.exp_hit !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midframe_reset: valid/busy/done/hit got %b%b%b%b cnt %0d expected 0000 cnt 0",
               bus.valid, bus.busy, bus.done, bus.exp_hit, bus.exp_cnt);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midframe_no_done: done/busy got %b%b expected 00", bus.done, bus.busy);
      end
    end
    run_frame("after_reset", 16'hBBBB, 0, 1'b0, 17);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] frame;
    bit inj;
    for (int n = 0; n < 8; n++) begin
      frame = WIDTH'($urandom);
      inj   = 1'($urandom_range(0, 1));
      run_frame("random", frame, 2, inj, -1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    test_reset();
    test_continuous();
    test_back_to_back();
    test_ready_toggle();
    test_ignored_load();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
